board_merge_ctrl: RTL and testbench
===================================

BOARD_MERGE_CTRL -- requirements
Module: board_merge_ctrl

Interface
REQ-001 Parameter WIDTH, 32: board row width in bits; equals the shared OR datapath width.
REQ-002 Parameter ROWS, 20: number of valid board rows, addressed 0..ROWS-1.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port start, input, 1: request a merge; sampled only in IDLE.
REQ-006 Port base_row, input, 5: board row receiving piece row 0.
REQ-007 Port piece_mask, input, 4*WIDTH: piece rows 0..3; row i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port mem_rd_en, output, 1: board-memory read strobe; read data arrives 1 cycle later.
REQ-009 Port mem_wr_en, output, 1: board-memory write strobe.
REQ-010 Port mem_addr, output, 5: board-memory row address for the read or write.
REQ-011 Port mem_rdata, input, WIDTH: board-memory read data.
REQ-012 Port mem_wdata, output, WIDTH: merged row written back.
REQ-013 Port busy, output, 1: high from the cycle after start is accepted until done.
REQ-014 Port done, output, 1: one-cycle pulse when the merge completes.
REQ-015 Port full_rows, output, 4: bit i set when merged row i is all ones; valid with done, held until the next accept.
REQ-016 Port full_count, output, 3: popcount of full_rows; same validity.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, WRITE, DONE.
REQ-018 In IDLE with start=1, the block SHALL latch base_row and piece_mask, clear full_rows and full_count, set row index i=0, and go to READ.
REQ-019 READ SHALL assert mem_rd_en with mem_addr=base_row+i for one cycle, then go to WAIT.
REQ-020 WAIT SHALL capture mem_rdata, then go to WRITE.
REQ-021 WRITE SHALL assert mem_wr_en with mem_addr=base_row+i and mem_wdata=captured OR piece row i, and SHALL set full_rows[i] if mem_wdata is all ones.
REQ-022 After WRITE, the FSM SHALL go to READ for the next valid row, or to DONE after the last valid row.
REQ-023 Rows with base_row+i >= ROWS SHALL be skipped with no memory access and full_rows[i]=0; the address sum SHALL be computed 6 bits wide, with no wrap-around.
REQ-024 If no row is valid (base_row >= ROWS), the FSM SHALL go IDLE -> DONE directly.
REQ-025 DONE SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-026 Latency from start accepted to done SHALL be 3*N+1 cycles, where N is the number of valid rows (0..4).
REQ-027 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-028 mem_rd_en and mem_wr_en SHALL never be high in the same cycle; mem_addr and mem_wdata SHALL be 0 when both are low.
REQ-029 A zero piece row SHALL still be read and written back unchanged.

Reset
REQ-030 reset_n low SHALL immediately force IDLE and drive busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, full_rows and full_count to 0.
REQ-031 Reset mid-operation SHALL abandon the merge with no further memory access; rows already written SHALL stay written.

Structure
REQ-032 Shared package board_pkg SHALL hold ROWS, WIDTH, the FSM state enum, and the all-ones row constant.
REQ-033 The merge SHALL use one instance of sub-module bitwise_or (32-bit OR), shared across all four rows; no other OR datapath is permitted.

Verification
REQ-034 base_row=5, memory rows 5..8=0, piece rows {0xF,0xF0,0,0} -> 12 memory cycles, rows 5..8 = {0xF,0xF0,0,0}, done at cycle 13, full_count=0.
REQ-035 Row 19=0xFFFF_FFF0, base_row=19, piece row 0=0xF -> one row only, row 19=0xFFFF_FFFF, full_rows=4'b0001, full_count=1, done at cycle 4.
REQ-036 base_row=25 -> no memory access, done at cycle 1, full_rows=0.
REQ-037 start pulsed at cycles 2 and 7 of an active merge -> ignored; exactly one done; start in the cycle after done -> accepted.
REQ-038 reset_n dropped during WAIT of row 2 -> all outputs 0 immediately, rows 0..1 updated, rows 2..3 unchanged, IDLE after reset_n rises.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, merge FSM states and the full-row constant
package board_pkg;
  localparam int WIDTH = 32;
  localparam int ROWS = 20;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/board_merge_ctrl_if.sv
// board_merge_ctrl_if: merge request/status and board-memory bus bundle
interface board_merge_ctrl_if;
  logic start;
  logic [4:0] base_row;
  logic [4*board_pkg::WIDTH-1:0] piece_mask;
  logic busy;
  logic done;
  logic [3:0] full_rows;
  logic [2:0] full_count;
  logic mem_rd_en;
  logic mem_wr_en;
  logic [4:0] mem_addr;
  logic [board_pkg::WIDTH-1:0] mem_rdata;
  logic [board_pkg::WIDTH-1:0] mem_wdata;
  modport master (
    input start, base_row, piece_mask, mem_rdata,
    output busy, done, full_rows, full_count, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
  modport slave (
    output start, base_row, piece_mask, mem_rdata,
    input busy, done, full_rows, full_count, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bitwise_or.sv
// bitwise_or: the single OR datapath shared by all piece rows
module bitwise_or #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a | b;
endmodule

// File: rtl/board_merge_ctrl.sv
// board_merge_ctrl: read-OR-write merge of a 4-row piece into board memory
module board_merge_ctrl
  import board_pkg::*;
#(
  parameter int WIDTH = board_pkg::WIDTH,
  parameter int ROWS = board_pkg::ROWS
) (
  input logic clock,
  input logic reset_n,
  board_merge_ctrl_if.master bus
);
  state_t state, next;
  logic [4:0] base_q;
  logic [4*WIDTH-1:0] piece_q;
  logic [1:0] idx;
  logic [WIDTH-1:0] rdata_q;
  logic [3:0] full_q;
  logic [WIDTH-1:0] or_y;
  logic [5:0] addr6;
  logic first_valid;
  logic more;
  // Address sums are 6 bits so rows past the board never alias onto low rows.
  assign addr6 = {1'b0, base_q} + {4'b0, idx};
  assign first_valid = {1'b0, bus.base_row} < 6'(ROWS);
  assign more = idx != 2'd3 && addr6 + 6'd1 < 6'(ROWS);
  bitwise_or #(.WIDTH(WIDTH)) u_or (
    .a(rdata_q),
    .b(piece_q[int'(idx)*WIDTH +: WIDTH]),
    .y(or_y)
  );
  assign bus.busy = state == READ || state == WAIT || state == WRITE;
  assign bus.done = state == DONE;
  assign bus.full_rows = full_q;
  assign bus.full_count = {2'b0, full_q[0]} + {2'b0, full_q[1]} + {2'b0, full_q[2]} + {2'b0, full_q[3]};
  // State, latched request, captured read data and per-row full flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base_q <= '0;
      piece_q <= '0;
      idx <= '0;
      rdata_q <= '0;
      full_q <= '0;
    end else begin
      state <= next;
      if (state == IDLE && bus.start) begin
        base_q <= bus.base_row;
        piece_q <= bus.piece_mask;
        idx <= '0;
        full_q <= '0;
      end
      if (state == WAIT) rdata_q <= bus.mem_rdata;
      if (state == WRITE) begin
        full_q[idx] <= or_y == ALL_ONES;
        idx <= idx + 2'd1;
      end
    end
  end
  // Next state and memory strobes; address and data stay zero when idle.
  always_comb begin
    next = state;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: if (bus.start) next = first_valid ? READ : DONE;
      READ: begin
        next = WAIT;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr = addr6[4:0];
      end
      WAIT: next = WRITE;
      WRITE: begin
        next = more ? READ : DONE;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr = addr6[4:0];
        bus.mem_wdata = or_y;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_board_merge_ctrl.sv
// tb_board_merge_ctrl: directed merge scenarios against a 1-cycle board memory model
module tb_board_merge_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  board_merge_ctrl_if bus ();
  board_merge_ctrl dut (.clock(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [32];
  logic rd_s = 1'b0, wr_s = 1'b0;
  logic [4:0] addr_s = '0;
  logic [31:0] wdata_s = '0;
  int acc = 0, viol = 0, total = 0, bad = 0;
  // Bus monitor: sample strobes mid-cycle and flag illegal bus states.
  always @(negedge clk) begin
    rd_s = bus.mem_rd_en;
    wr_s = bus.mem_wr_en;
    addr_s = bus.mem_addr;
    wdata_s = bus.mem_wdata;
    if (rd_s || wr_s) acc++;
    if (rd_s && wr_s) viol++;
    if (!rd_s && !wr_s && (addr_s != 0 || wdata_s != 0)) viol++;
    if ((rd_s || wr_s) && addr_s >= 5'd20) viol++;
  end
  // Board memory: read data valid only in the cycle after the read strobe.
  always @(posedge clk) begin
    if (wr_s) mem[addr_s] = wdata_s;
    bus.mem_rdata <= rd_s ? mem[addr_s] : 32'hDEAD_BEEF;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [4:0] b, input logic [127:0] p, output int lat);
    @(negedge clk);
    bus.base_row = b;
    bus.piece_mask = p;
    bus.start = 1'b1;
    acc = 0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 0);
    check({tag, "_done"}, 64'(bus.done), 0);
    check({tag, "_rdwr"}, 64'({bus.mem_rd_en, bus.mem_wr_en}), 0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 0);
    check({tag, "_full"}, 64'({bus.full_rows, bus.full_count}), 0);
  endtask
  int lat, dn, d1, d2;
  logic b15;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    bus.start = 1'b0;
    bus.base_row = '0;
    bus.piece_mask = '0;
    #3 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem[4] = 32'h1234_5678;
    mem[9] = 32'h8765_4321;
    run(5'd5, {32'h0, 32'h0, 32'hF0, 32'hF}, lat);
    check("t1_lat", 64'(lat), 13);
    check("t1_acc", 64'(acc), 8);
    check("t1_row5", 64'(mem[5]), 64'h0F);
    check("t1_row6", 64'(mem[6]), 64'hF0);
    check("t1_row7_8", 64'({mem[7], mem[8]}), 0);
    check("t1_neighbors", 64'({mem[4], mem[9]}), 64'h1234_5678_8765_4321);
    check("t1_full", 64'({bus.full_rows, bus.full_count}), 0);
    mem[19] = 32'hFFFF_FFF0;
    run(5'd19, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF}, lat);
    check("t2_lat", 64'(lat), 4);
    check("t2_acc", 64'(acc), 2);
    check("t2_row19", 64'(mem[19]), 64'hFFFF_FFFF);
    check("t2_full_rows", 64'(bus.full_rows), 4'b0001);
    check("t2_full_count", 64'(bus.full_count), 1);
    run(5'd25, {4{32'hFFFF_FFFF}}, lat);
    check("t3_lat", 64'(lat), 1);
    check("t3_acc", 64'(acc), 0);
    check("t3_full", 64'({bus.full_rows, bus.full_count}), 0);
    mem[0] = 32'hFFFF_0000;
    mem[1] = 32'h0;
    mem[2] = 32'hAAAA_5555;
    mem[3] = 32'h1;
    run(5'd0, {32'h0, 32'h5555_AAAA, 32'hFFFF_FFFF, 32'h0000_FFFF}, lat);
    check("t4_lat", 64'(lat), 13);
    check("t4_rows", {mem[1], mem[2]}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check("t4_row0", 64'(mem[0]), 64'hFFFF_FFFF);
    check("t4_zero_piece_row", 64'(mem[3]), 1);
    check("t4_full_rows", 64'(bus.full_rows), 4'b0111);
    check("t4_full_count", 64'(bus.full_count), 3);
    mem[17] = 32'h0;
    mem[18] = 32'h0;
    mem[19] = 32'h0;
    run(5'd17, {4{32'hFFFF_FFFF}}, lat);
    check("t5_lat", 64'(lat), 10);
    check("t5_acc", 64'(acc), 6);
    check("t5_full_rows", 64'(bus.full_rows), 4'b0111);
    check("t5_full_count", 64'(bus.full_count), 3);
    @(negedge clk);
    bus.base_row = 5'd0;
    bus.piece_mask = {32'h8, 32'h4, 32'h2, 32'h1};
    bus.start = 1'b1;
    dn = 0;
    d1 = 0;
    d2 = 0;
    b15 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (dn == 1) d1 = c;
        else d2 = c;
      end
      if (c == 15) b15 = bus.busy;
      bus.start = c == 2 || c == 7 || c == 13 || c == 14;
    end
    bus.start = 1'b0;
    check("t6_done_count", 64'(dn), 2);
    check("t6_first_done", 64'(d1), 13);
    check("t6_second_done", 64'(d2), 27);
    check("t6_busy_after_reaccept", 64'(b15), 1);
    mem[10] = 32'hFFFF_FFFE;
    mem[11] = 32'h100;
    mem[12] = 32'h100;
    mem[13] = 32'h100;
    @(negedge clk);
    bus.base_row = 5'd10;
    bus.piece_mask = {32'h4, 32'h3, 32'h2, 32'h1};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 2; c <= 8; c++) @(negedge clk);
    check("t7_busy_in_wait", 64'(bus.busy), 1);
    check("t7_full_before_reset", 64'(bus.full_rows), 4'b0001);
    rst_n = 1'b0;
    acc = 0;
    #1 check_idle_outputs("t7_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("t7_after");
    check("t7_acc", 64'(acc), 0);
    check("t7_rows_done", {mem[10], mem[11]}, {32'hFFFF_FFFF, 32'h102});
    check("t7_rows_left", {mem[12], mem[13]}, {32'h100, 32'h100});
    check("bus_violations", 64'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
